// File: rtl/seg_scan_mux_if.sv
// Display bus for seg_scan_mux: load request plus the multiplexed digit outputs.
interface seg_scan_mux_if;
    logic        load;
    logic [15:0] value;
    logic [3:0]  digit_data;
    logic [3:0]  digit_sel;
    logic        frame_done;

    modport master (
        output load,
        output value,
        input  digit_data,
        input  digit_sel,
        input  frame_done
    );

    modport slave (
        input  load,
        input  value,
        output digit_data,
        output digit_sel,
        output frame_done
    );
endinterface

// File: rtl/seg_scan_mux.sv
// Four-digit time-multiplexed 7-segment scanner with frame-synchronous value update.
// Optional leading-zero blanking is enabled by defining SEG_SCAN_BLANK_EN.
module seg_scan_mux #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic          clk,
    input  logic          reset,
    seg_scan_mux_if.slave bus
);

    localparam logic [15:0] LAST_COUNT = 16'(REFRESH_DIV - 1);

    logic [15:0] count_r;
    logic [1:0]  index_r;
    logic [15:0] display_r;
    logic [15:0] pending_r;
    logic        pending_flag_r;
    logic        frame_done_r;
    logic        tick_s;
    logic        wrap_s;
    logic [3:0]  nibble_s;
    logic [3:0]  data_s;
    logic [3:0]  sel_s;

`ifdef SEG_SCAN_BLANK_EN
    function automatic logic leading_zero(input logic [15:0] disp, input logic [1:0] idx);
        logic result;
        case (idx)
            2'd3:    result = (disp[15:12] == 4'h0);
            2'd2:    result = (disp[15:8] == 8'h00);
            2'd1:    result = (disp[15:4] == 12'h000);
            default: result = 1'b0;
        endcase
        return result;
    endfunction
`endif

    assign tick_s = (count_r == LAST_COUNT);
    assign wrap_s = tick_s && (index_r == 2'd3);

    // Prescaler and digit index; load never disturbs the scan timing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= 16'd0;
            index_r <= 2'd0;
        end else if (tick_s) begin
            count_r <= 16'd0;
            index_r <= index_r + 2'd1;
        end else begin
            count_r <= count_r + 16'd1;
        end
    end

    // Pending/display registers: new values only become visible at a frame boundary.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            display_r      <= 16'h0000;
            pending_r      <= 16'h0000;
            pending_flag_r <= 1'b0;
        end else if (wrap_s && bus.load) begin
            display_r      <= bus.value;
            pending_r      <= bus.value;
            pending_flag_r <= 1'b0;
        end else if (wrap_s && pending_flag_r) begin
            display_r      <= pending_r;
            pending_flag_r <= 1'b0;
        end else if (bus.load) begin
            pending_r      <= bus.value;
            pending_flag_r <= 1'b1;
        end
    end

    // Frame completion strobe, one cycle after the 3->0 tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= wrap_s;
        end
    end

    // Digit enable and nibble selection straight from the index register.
    always_comb begin
        sel_s    = 4'b0001;
        nibble_s = display_r[3:0];
        case (index_r)
            2'd0: begin sel_s = 4'b0001; nibble_s = display_r[3:0];   end
            2'd1: begin sel_s = 4'b0010; nibble_s = display_r[7:4];   end
            2'd2: begin sel_s = 4'b0100; nibble_s = display_r[11:8];  end
            2'd3: begin sel_s = 4'b1000; nibble_s = display_r[15:12]; end
            default: begin sel_s = 4'b0001; nibble_s = display_r[3:0]; end
        endcase
    end

    // Optional blanking; 4'hF is outside BCD so the decoder turns the digit off.
    always_comb begin
        data_s = nibble_s;
`ifdef SEG_SCAN_BLANK_EN
        if (leading_zero(display_r, index_r)) begin
            data_s = 4'hF;
        end else begin
            data_s = nibble_s;
        end
`endif
    end

    assign bus.digit_sel  = sel_s;
    assign bus.digit_data = data_s;
    assign bus.frame_done = frame_done_r;

endmodule
